// File: rtl/sram_pipe.sv
// Single-port pipelined SRAM with a post-reset zero-clear, sideband storage and optional output register.
// Define SRAM_PIPE_PARITY_EN to store one even-parity bit per byte and flag mismatches on read.
module sram_pipe #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned USER_WIDTH    = 1,
    parameter int unsigned USER_EN       = 0,
    parameter int unsigned NUM_WORDS     = 1024,
    parameter int unsigned OUT_REGS      = 0,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic                         we_i,
    input  logic [$clog2(NUM_WORDS)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [(DATA_WIDTH+7)/8-1:0]  be_i,
    input  logic [USER_WIDTH-1:0]        wuser_i,
    output logic                         rvalid_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [USER_WIDTH-1:0]        ruser_o,
    output logic                         init_done_o,
    output logic                         err_o
);

    localparam int unsigned   AW        = $clog2(NUM_WORDS);
    localparam int unsigned   BW        = (DATA_WIDTH + 7) / 8;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         init_addr_q, init_addr_d;

    logic                  ready, in_range, rd_en, par_err;
    logic                  mem_we, user_we;
    logic [AW-1:0]         mem_addr, rd_idx;
    logic [DATA_WIDTH-1:0] mem_wdata, bit_mask, rd_word;
    logic [BW-1:0]         mem_wbe;
    logic [USER_WIDTH-1:0] mem_wuser, user_rd;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    // Outputs are gated by rst_ni so they drop the moment reset asserts, even when reset lands in READY.
    assign ready       = (state_q == READY) && rst_ni;
    assign gnt_o       = req_i && ready;
    assign init_done_o = ready;
    assign in_range    = 32'(addr_i) < NUM_WORDS;
    assign rd_en       = gnt_o && !we_i;
    assign rd_idx      = in_range ? addr_i : '0;
    assign rd_word     = mem[rd_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= (INIT_ON_RESET != 0) ? INIT : READY;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        mem_we      = 1'b0;
        user_we     = 1'b0;
        mem_addr    = addr_i;
        mem_wdata   = wdata_i;
        mem_wbe     = be_i;
        mem_wuser   = wuser_i;
        case (state_q)
            INIT: begin
                mem_we    = rst_ni;
                user_we   = 1'b1;
                mem_addr  = init_addr_q;
                mem_wdata = '0;
                mem_wbe   = '1;
                mem_wuser = '0;
                if (init_addr_q == LAST_ADDR) begin
                    state_d     = READY;
                    init_addr_d = '0;
                end else begin
                    init_addr_d = init_addr_q + 1'b1;
                end
            end
            READY: begin
                mem_we  = gnt_o && we_i && in_range;
                user_we = |be_i;
            end
        endcase
    end

    always_comb begin
        bit_mask = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            bit_mask[i] = mem_wbe[i / 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_addr] <= (mem[mem_addr] & ~bit_mask) | (mem_wdata & bit_mask);
        end
    end

`ifdef SRAM_PIPE_PARITY_EN
    logic [BW-1:0] par_mem [NUM_WORDS];

    function automatic logic [BW-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [BW-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            p[i / 8] = p[i / 8] ^ d[i];
        end
        return p;
    endfunction

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            par_mem[mem_addr] <= (par_mem[mem_addr] & ~mem_wbe) | (byte_parity(mem_wdata) & mem_wbe);
        end
    end

    assign par_err = |(par_mem[rd_idx] ^ byte_parity(rd_word));
`else
    assign par_err = 1'b0;
`endif

    if (USER_EN != 0) begin : g_user
        logic [USER_WIDTH-1:0] user_mem [NUM_WORDS];

        always_ff @(posedge clk_i) begin
            if (mem_we && user_we) begin
                user_mem[mem_addr] <= mem_wuser;
            end
        end

        assign user_rd = user_mem[rd_idx];
    end else begin : g_no_user
        logic unused_user;
        assign unused_user = ^{mem_wuser, user_we};
        assign user_rd     = '0;
    end

    logic                  rvalid_q, err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [USER_WIDTH-1:0] ruser_q;

    // Data registers only load on a read so they hold the last returned word in idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            ruser_q  <= '0;
        end else begin
            rvalid_q <= rd_en;
            err_q    <= rd_en && (!in_range || par_err);
            if (rd_en) begin
                rdata_q <= in_range ? rd_word : '0;
                ruser_q <= in_range ? user_rd : '0;
            end
        end
    end

    if (OUT_REGS != 0) begin : g_out_reg
        logic                  rvalid_r, err_r;
        logic [DATA_WIDTH-1:0] rdata_r;
        logic [USER_WIDTH-1:0] ruser_r;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_r <= 1'b0;
                err_r    <= 1'b0;
                rdata_r  <= '0;
                ruser_r  <= '0;
            end else begin
                rvalid_r <= rvalid_q;
                err_r    <= err_q;
                if (rvalid_q) begin
                    rdata_r <= rdata_q;
                    ruser_r <= ruser_q;
                end
            end
        end

        assign rvalid_o = rvalid_r;
        assign err_o    = err_r;
        assign rdata_o  = rdata_r;
        assign ruser_o  = ruser_r;
    end else begin : g_no_out_reg
        assign rvalid_o = rvalid_q;
        assign err_o    = err_q;
        assign rdata_o  = rdata_q;
        assign ruser_o  = ruser_q;
    end

endmodule

// File: doc/sram_pipe.md
SRAM_PIPE -- requirements
Module: sram_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 64: data word width in bits, any value >= 8.
REQ-002 Parameter USER_WIDTH, default 1: user sideband width in bits.
REQ-003 Parameter USER_EN, default 0: 1 stores the user sideband; 0 ties ruser_o to 0.
REQ-004 Parameter NUM_WORDS, default 1024: depth, any value >= 2, not restricted to powers of 2.
REQ-005 Parameter OUT_REGS, default 0: 0 gives read latency 1; 1 adds an output register stage for read latency 2.
REQ-006 Parameter INIT_ON_RESET, default 1: 1 zero-clears the array after reset; 0 skips the clear.
REQ-007 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_ni  in  1  reset, asynchronous and active-low.
REQ-009 req_i  in  1  access request.
REQ-010 gnt_o  out  1  request accepted this cycle.
REQ-011 we_i  in  1  1 = write, 0 = read.
REQ-012 addr_i  in  $clog2(NUM_WORDS)  word address.
REQ-013 wdata_i  in  DATA_WIDTH  write data.
REQ-014 be_i  in  (DATA_WIDTH+7)/8  byte enables; bit k covers data bits [8k+7:8k], truncated at the top byte.
REQ-015 wuser_i  in  USER_WIDTH  write sideband; it is written whenever any bit of be_i is set.
REQ-016 rvalid_o  out  1  rdata_o and ruser_o are valid this cycle.
REQ-017 rdata_o  out  DATA_WIDTH  read data.
REQ-018 ruser_o  out  USER_WIDTH  read sideband.
REQ-019 init_done_o  out  1  the array is ready for access.
REQ-020 err_o  out  1  error pulse, asserted for one cycle with rvalid_o.

Function
REQ-021 The controller SHALL have two states: INIT and READY.
- After reset the controller enters INIT if INIT_ON_RESET=1, otherwise READY.
REQ-022 INIT SHALL write zero data and zero user bits to addresses 0..NUM_WORDS-1, one address per cycle, and SHALL move to READY after address NUM_WORDS-1.
- INIT therefore lasts exactly NUM_WORDS cycles.
REQ-023 gnt_o SHALL equal req_i AND (state==READY), so gnt_o is 0 throughout INIT.
REQ-024 init_done_o SHALL be 1 exactly when state==READY.
REQ-025 A granted write SHALL update only the enabled bytes and SHALL NOT assert rvalid_o.
REQ-026 A granted read SHALL assert rvalid_o exactly 1+OUT_REGS cycles after the grant.
- Reads are fully pipelined: back-to-back reads give back-to-back rvalid_o.
REQ-027 rdata_o and ruser_o SHALL hold their last valid value while rvalid_o=0.
REQ-028 A read in the cycle directly after a write to the same address SHALL return the post-write data.
REQ-029 An access with addr_i >= NUM_WORDS SHALL be granted and SHALL have no effect on the array.
- Such a write is dropped.
- Such a read returns zero data with err_o=1.

Reset
REQ-030 Asserting rst_ni SHALL immediately force: rvalid_o=0, err_o=0, gnt_o=0, rdata_o=0, ruser_o=0, init_done_o=0, and clear the pipeline.
REQ-031 Reset asserted during INIT SHALL restart the clear from address 0.
- Array contents SHALL NOT be reset except by INIT.

Configuration
REQ-032 The macro SRAM_PIPE_PARITY_EN SHALL control per-byte even parity.
- With the macro defined: one parity bit per byte is stored on write and checked on read.
- A mismatch asserts err_o together with rvalid_o; rdata_o returns the stored data unmodified.
- Without the macro: no parity storage exists, and err_o is driven only by the out-of-range rule in REQ-029.

Verification
REQ-033 NUM_WORDS=16, INIT_ON_RESET=1: release reset with req_i held 1 -> gnt_o=0 for exactly 16 cycles, then init_done_o=1 and gnt_o=1; a read of addr 5 returns 0.
REQ-034 OUT_REGS=0: write 0x1122334455667788 to addr 3 with be=0xFF, then write 0xAA..AA with be=0x01, then read addr 3 -> rvalid_o one cycle later, rdata_o=0x11223344556677AA.
REQ-035 OUT_REGS=1: reads of addr 0,1,2 on consecutive cycles -> rvalid_o high on cycles 2,3,4 after the first grant, with data in order.
REQ-036 DATA_WIDTH=36, USER_EN=1: write 0xF_0000_0001 with wuser=1, then read on the next cycle -> rdata_o=0xF00000001, ruser_o=1.
REQ-037 NUM_WORDS=12: read addr 13 -> rvalid_o=1, rdata_o=0, err_o=1; with the macro defined, corrupt the stored parity of byte 0 via backdoor -> the next read of that word asserts err_o=1.
REQ-038 Assert rst_ni low mid-INIT at address 7 and release -> the clear restarts, and init_done_o rises NUM_WORDS cycles after release.
